// File: rtl/memory_controller_if.sv
// memory_controller_if: LSB/IF request ports and the byte-wide RAM/IO bus
interface memory_controller_if;
  logic        lsb_flag;
  logic        lsb_op;
  logic [31:0] lsb_addr;
  logic [2:0]  lsb_len;
  logic [31:0] lsb_data;
  logic        lsb_done;
  logic [31:0] lsb_val;
  logic        if_flag;
  logic [31:0] if_pc;
  logic        if_done;
  logic [31:0] if_inst;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  modport slave (
    input  lsb_flag, lsb_op, lsb_addr, lsb_len, lsb_data, if_flag, if_pc, mem_din, io_buffer_full,
    output lsb_done, lsb_val, if_done, if_inst, mem_dout, mem_a, mem_wr
  );
  modport master (
    output lsb_flag, lsb_op, lsb_addr, lsb_len, lsb_data, if_flag, if_pc, mem_din, io_buffer_full,
    input  lsb_done, lsb_val, if_done, if_inst, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/memory_controller.sv
// memory_controller: byte-serial LSB/IF responder on the RAM/IO bus; MC_IO_STALL_EN enables IO write stalls
module memory_controller #(
  parameter logic [1:0] IO_SEL = 2'b11,
  parameter int FETCH_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy_i,
  input  logic roll_i,
  memory_controller_if.slave bus
);
`ifdef MC_IO_STALL_EN
  localparam bit IO_STALL = 1'b1;
`else
  localparam bit IO_STALL = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;
  state_e state_q, state_d;
  logic src_q, src_d;
  logic [2:0] cnt_q, cnt_d, len_q, len_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, buf_q, buf_d;
  logic [31:0] mem_a_q, mem_a_d, lsb_val_q, lsb_val_d, if_inst_q, if_inst_d;
  logic [7:0] mem_dout_q, mem_dout_d;
  logic mem_wr_q, mem_wr_d, lsb_done_q, lsb_done_d, if_done_q, if_done_d;
  logic stall, go, last, accept, acc_wr;
  logic [31:0] nxt_a, rd_buf;
  assign stall = IO_STALL && state_q == WRITE && mem_a_q[17:16] == IO_SEL && bus.io_buffer_full;
  assign go = rdy_i && !stall;
  assign last = cnt_q == len_q - 3'd1;
  assign nxt_a = addr_q + 32'(cnt_q) + 32'd1;
  assign rd_buf = buf_q | (32'(bus.mem_din) << {cnt_q, 3'b000});
  assign accept = !lsb_done_q && !if_done_q && !roll_i && (bus.lsb_flag || bus.if_flag);
  assign acc_wr = bus.lsb_flag && bus.lsb_op;
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    cnt_d = cnt_q;
    len_d = len_q;
    addr_d = addr_q;
    data_d = data_q;
    buf_d = buf_q;
    mem_a_d = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d = mem_wr_q;
    lsb_val_d = lsb_val_q;
    if_inst_d = if_inst_q;
    lsb_done_d = 1'b0;
    if_done_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        src_d = !bus.lsb_flag;
        addr_d = bus.lsb_flag ? bus.lsb_addr : bus.if_pc;
        len_d = bus.lsb_flag ? bus.lsb_len : 3'(FETCH_LEN);
        data_d = bus.lsb_data;
        cnt_d = '0;
        buf_d = '0;
        mem_a_d = bus.lsb_flag ? bus.lsb_addr : bus.if_pc;
        mem_dout_d = bus.lsb_data[7:0];
        mem_wr_d = acc_wr;
        state_d = acc_wr ? WRITE : READ;
      end
      READ: if (roll_i) begin
        state_d = IDLE;
        mem_a_d = '0;
        mem_wr_d = 1'b0;
      end else if (last) begin
        state_d = IDLE;
        mem_a_d = '0;
        lsb_done_d = !src_q;
        if_done_d = src_q;
        lsb_val_d = src_q ? lsb_val_q : rd_buf;
        if_inst_d = src_q ? rd_buf : if_inst_q;
      end else begin
        buf_d = rd_buf;
        mem_a_d = nxt_a;
        cnt_d = cnt_q + 3'd1;
      end
      WRITE: if (last) begin
        state_d = IDLE;
        mem_a_d = '0;
        mem_wr_d = 1'b0;
        lsb_done_d = 1'b1;
      end else begin
        mem_a_d = nxt_a;
        mem_dout_d = 8'(data_q >> {cnt_q + 3'd1, 3'b000});
        cnt_d = cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      src_q <= 1'b0;
      cnt_q <= '0;
      len_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      buf_q <= '0;
      mem_a_q <= '0;
      mem_dout_q <= '0;
      mem_wr_q <= 1'b0;
      lsb_done_q <= 1'b0;
      lsb_val_q <= '0;
      if_done_q <= 1'b0;
      if_inst_q <= '0;
    end else if (go) begin
      state_q <= state_d;
      src_q <= src_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      addr_q <= addr_d;
      data_q <= data_d;
      buf_q <= buf_d;
      mem_a_q <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q <= mem_wr_d;
      lsb_done_q <= lsb_done_d;
      lsb_val_q <= lsb_val_d;
      if_done_q <= if_done_d;
      if_inst_q <= if_inst_d;
    end
  assign bus.lsb_done = lsb_done_q;
  assign bus.lsb_val = lsb_val_q;
  assign bus.if_done = if_done_q;
  assign bus.if_inst = if_inst_q;
  assign bus.mem_a = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr = mem_wr_q && go;
endmodule
